// File: rtl/kl8e_keyboard_rx.sv
// KL8E console keyboard receiver (device 03): 8N1 serial rx, char buffer, flag and IOT 603x decode.
// Optional RX_OVERRUN_PROTECT_EN keeps the unread char and raises sticky overrun. PDP-8 bit 0 is vector bit 11.
module kl8e_keyboard_rx #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        iot,
  input  logic [11:0] instruction,
  input  logic [11:0] ac,
  output logic        skip,
  output logic        clear_ac,
  output logic [11:0] ac_data,
  output logic        irq,
  output logic        overrun
);
  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    buffer;
  logic          rx_m, rx_s, rx_d;
  logic          done, accept;
  logic          kbd_flag, int_ena;
  logic          sel, flag_clr, kie;
  logic [2:0]    op;

  // rx_d trails rx_s so IDLE can see the mark-to-space edge
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    done    = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        bit_n = '0;
        if (rx_d && !rx_s) state_n = S_START;
      end
      S_START: begin
        if (cnt == HALF_BIT) begin
          cnt_n   = '0;
          state_n = rx_s ? S_IDLE : S_DATA;
        end else cnt_n = cnt + 1'b1;
      end
      S_DATA: begin
        if (cnt == LAST_CNT) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[7:1]};
          bit_n   = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = S_STOP;
        end else cnt_n = cnt + 1'b1;
      end
      S_STOP: begin
        if (cnt == LAST_CNT) begin
          cnt_n = '0;
          if (rx_s) begin
            done    = 1'b1;
            state_n = S_IDLE;
          end else state_n = S_BREAK;
        end else cnt_n = cnt + 1'b1;
      end
      S_BREAK: if (rx_s) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign sel      = iot && (instruction[11:3] == 9'o603);
  assign op       = instruction[2:0];
  assign flag_clr = sel && (op == 3'd0 || op == 3'd2 || op == 3'd6);
  assign kie      = sel && (op == 3'd5);
  assign skip     = sel && (op == 3'd1) && kbd_flag;
  assign clear_ac = sel && (op == 3'd2 || op == 3'd6);
  assign ac_data  = (sel && (op == 3'd4 || op == 3'd6)) ? {4'b0000, buffer} : 12'o0000;
  assign irq      = kbd_flag & int_ena;

`ifdef RX_OVERRUN_PROTECT_EN
  // a read in the completing cycle frees the buffer, so that char is kept
  assign accept = done && (!kbd_flag || flag_clr);

  always_ff @(posedge clk) begin
    if (reset) overrun <= 1'b0;
    else if (done && !accept) overrun <= 1'b1;
    else if (flag_clr) overrun <= 1'b0;
  end
`else
  assign accept  = done;
  assign overrun = 1'b0;
`endif

  // completion outranks a clearing IOT on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      kbd_flag <= 1'b0;
      buffer   <= 8'o000;
      int_ena  <= 1'b1;
    end else begin
      if (accept) begin
        buffer   <= shift;
        kbd_flag <= 1'b1;
      end else if (flag_clr) kbd_flag <= 1'b0;
      if (kie) int_ena <= ac[0];
    end
  end
endmodule
